// File: rtl/stopwatch_timer_ctrl.sv
// BCD stopwatch/timer with start/pause, lap hold, terminal-count stop and
// a multiplexed active-low 7-segment display driver.

module stopwatch_digit (
  input  logic [3:0] d,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] q,
  output logic       cout
);
  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin q = 4'd0; cout = 1'b1; end
        else q = d + 4'd1;
      end else begin
        if (d == 4'd0) begin q = 4'd9; cout = 1'b1; end
        else q = d - 4'd1;
      end
    end
  end
endmodule

module stopwatch_timer_ctrl #(
  parameter int N_DIGITS      = 4,
  parameter int PRESET_DIGITS = 2,
  parameter int TICK_DIV      = 1000000,
  parameter int REFRESH_DIV   = 100000,
  parameter int DP_POS        = 2
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startstop,
  input  logic                       lap,
  input  logic [1:0]                 mode,
  input  logic [4*PRESET_DIGITS-1:0] preset,
  output logic [N_DIGITS-1:0]        an,
  output logic [6:0]                 sseg,
  output logic                       dp,
  output logic                       running,
  output logic                       done
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef logic [N_DIGITS-1:0][3:0] bcd_t;

  state_t         state, state_n;
  logic [1:0]     mode_q;
  bcd_t           cnt, cnt_inc, load_val, lap_val, disp;
  logic           hold;
  logic [TW-1:0]  presc;
  logic [RW-1:0]  rcnt;
  logic [IW-1:0]  idx;
  logic [N_DIGITS-1:0] cin, cout;
  logic           up, tick, at_term, next_term, done_tick, mode_chg;
  logic [N_DIGITS-1:0] an_d;
  logic [6:0]     sseg_d;
  logic           dp_d, running_d, done_d;

  function automatic logic [6:0] seg_lo(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  // Load value is built from the live mode input: used on reset and on a mode change.
  always_comb begin
    load_val = '0;
    if (mode == 2'd2)
      for (int i = 0; i < N_DIGITS; i++) load_val[i] = 4'd9;
    if (mode[0])
      for (int i = 0; i < PRESET_DIGITS; i++)
        load_val[N_DIGITS-PRESET_DIGITS+i] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
  end

  assign up  = ~mode_q[1];
  assign cin = {cout[N_DIGITS-2:0], 1'b1};

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    stopwatch_digit u_dig (
      .d    (cnt[g]),
      .cin  (cin[g]),
      .up   (up),
      .q    (cnt_inc[g]),
      .cout (cout[g])
    );
  end

  // Carry/borrow out of the top digit means every digit already sits at 9 (up) or 0 (down).
  assign at_term = cout[N_DIGITS-1];

  always_comb begin
    next_term = 1'b1;
    for (int i = 0; i < N_DIGITS; i++)
      if (cnt_inc[i] != (up ? 4'd9 : 4'd0)) next_term = 1'b0;
  end

  assign tick      = (state == RUN) && (presc == TW'(TICK_DIV - 1));
  assign done_tick = tick && (at_term || next_term);
  assign mode_chg  = (state != RUN) && (mode != mode_q);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (mode_chg) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (startstop) state_n = RUN;
        RUN:     if (done_tick) state_n = DONE;
                 else if (startstop) state_n = PAUSE;
        PAUSE:   if (startstop) state_n = RUN;
        default: state_n = DONE;
      endcase
    end
  end

  always_comb begin
    running_d = (state_n == RUN);
    done_d    = (state_n == DONE);
    disp      = hold ? lap_val : cnt;
    an_d      = '1;
    an_d[idx] = 1'b0;
    sseg_d    = seg_lo(disp[idx]);
    dp_d      = !(int'(idx) == DP_POS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q  <= mode;
      cnt     <= load_val;
      presc   <= '0;
      rcnt    <= '0;
      idx     <= '0;
      hold    <= 1'b0;
      lap_val <= '0;
    end else begin
      if (mode_chg) begin
        mode_q <= mode;
        cnt    <= load_val;
      end else if (tick && !at_term) begin
        cnt <= cnt_inc;
      end

      presc <= (state == RUN && state_n == RUN && !tick) ? presc + 1'b1 : '0;

      // Lap capture takes the pre-tick count of this edge.
      if (mode_chg || (state_n == DONE && state != DONE)) begin
        hold <= 1'b0;
      end else if (state == RUN && lap) begin
        hold <= ~hold;
        if (!hold) lap_val <= cnt;
      end

      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an      <= '1;
      sseg    <= 7'h7F;
      dp      <= 1'b1;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      an      <= an_d;
      sseg    <= sseg_d;
      dp      <= dp_d;
      running <= running_d;
      done    <= done_d;
    end
  end
endmodule
